// File: rtl/ux607_qspi_xip_linebuf.sv
`default_nettype none
// ============================================================================
// ux607_qspi_xip_linebuf
//   Single-line XIP read buffer in front of the QSPI ICB slave port.
//   Revision: 1.0
// ============================================================================
module ux607_qspi_xip_linebuf #(
    parameter int PA_SIZE    = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_icb_cmd_valid,
    output logic               i_icb_cmd_ready,
    input  logic [PA_SIZE-1:0] i_icb_cmd_addr,
    input  logic               i_icb_cmd_read,
    input  logic [31:0]        i_icb_cmd_wdata,
    output logic               i_icb_rsp_valid,
    input  logic               i_icb_rsp_ready,
    output logic [31:0]        i_icb_rsp_rdata,
    output logic               o_icb_cmd_valid,
    input  logic               o_icb_cmd_ready,
    output logic [PA_SIZE-1:0] o_icb_cmd_addr,
    output logic               o_icb_cmd_read,
    output logic [31:0]        o_icb_cmd_wdata,
    input  logic               o_icb_rsp_valid,
    output logic               o_icb_rsp_ready,
    input  logic [31:0]        o_icb_rsp_rdata,
    input  logic               invalidate
);

    localparam int WIDX  = $clog2(LINE_WORDS);
    localparam int TAG_W = PA_SIZE - WIDX - 2;
    localparam logic [WIDX-1:0] LAST_IDX = WIDX'(LINE_WORDS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HIT_RSP  = 3'd1;
    localparam logic [2:0] S_FILL_CMD = 3'd2;
    localparam logic [2:0] S_FILL_RSP = 3'd3;
    localparam logic [2:0] S_MISS_RSP = 3'd4;
    localparam logic [2:0] S_PT_CMD   = 3'd5;
    localparam logic [2:0] S_PT_RSP   = 3'd6;

    logic [2:0]         state;
    logic [PA_SIZE-3:0] addr_q;
    logic [31:0]        wdata_q;
    logic [TAG_W-1:0]   line_tag;
    logic               line_valid;
    logic               pending_inval;
    logic               pt_done;
    logic [WIDX-1:0]    cnt;
    logic [31:0]        line_mem [LINE_WORDS];
    logic [31:0]        hit_data;

    logic [TAG_W-1:0]   tag_in;
    logic [WIDX-1:0]    widx_in;
    logic [TAG_W-1:0]   tag_q;
    logic [WIDX-1:0]    widx_q;
    logic               accept;
    logic               hit;
    logic               unused_addr_bits;

    assign tag_in           = i_icb_cmd_addr[PA_SIZE-1:WIDX+2];
    assign widx_in          = i_icb_cmd_addr[WIDX+1:2];
    assign tag_q            = addr_q[PA_SIZE-3:WIDX];
    assign widx_q           = addr_q[WIDX-1:0];
    assign unused_addr_bits = ^i_icb_cmd_addr[1:0];

    assign accept = i_icb_cmd_valid & (state == S_IDLE);
    // An invalidate coincident with the accept forces the miss path.
    assign hit    = i_icb_cmd_read & line_valid & (line_tag == tag_in) & ~invalidate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            line_tag      <= '0;
            line_valid    <= 1'b0;
            pending_inval <= 1'b0;
            pt_done       <= 1'b0;
            cnt           <= '0;
            hit_data      <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= i_icb_cmd_addr[PA_SIZE-1:2];
                        wdata_q <= i_icb_cmd_wdata;
                        if (hit) begin
                            hit_data <= line_mem[widx_in];
                            state    <= S_HIT_RSP;
                        end else if (i_icb_cmd_read) begin
                            line_tag   <= tag_in;
                            line_valid <= 1'b0;
                            cnt        <= '0;
                            state      <= S_FILL_CMD;
                        end else begin
                            line_valid <= 1'b0;
                            state      <= S_PT_CMD;
                        end
                    end
                end
                S_HIT_RSP: begin
                    if (i_icb_rsp_ready) state <= S_IDLE;
                end
                S_FILL_CMD: begin
                    if (o_icb_cmd_ready) state <= S_FILL_RSP;
                end
                S_FILL_RSP: begin
                    if (o_icb_rsp_valid) begin
                        line_mem[cnt] <= o_icb_rsp_rdata;
                        if (cnt == LAST_IDX) begin
                            line_valid <= ~pending_inval;
                            state      <= S_MISS_RSP;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_FILL_CMD;
                        end
                    end
                end
                S_MISS_RSP: begin
                    if (i_icb_rsp_ready) begin
                        pending_inval <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                S_PT_CMD: begin
                    if (o_icb_cmd_ready) begin
                        pt_done <= 1'b0;
                        state   <= S_PT_RSP;
                    end
                end
                S_PT_RSP: begin
                    if (!pt_done) begin
                        if (o_icb_rsp_valid) pt_done <= 1'b1;
                    end else if (i_icb_rsp_ready) begin
                        pt_done <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Placed last so it overrides a line_valid set by the final fill beat.
            if (invalidate) begin
                line_valid <= 1'b0;
                if ((state == S_FILL_CMD) || (state == S_FILL_RSP)) pending_inval <= 1'b1;
            end
        end
    end

    assign i_icb_cmd_ready = (state == S_IDLE);
    assign i_icb_rsp_valid = (state == S_HIT_RSP) | (state == S_MISS_RSP) |
                             ((state == S_PT_RSP) & pt_done);
    assign i_icb_rsp_rdata = (state == S_HIT_RSP)  ? hit_data :
                             (state == S_MISS_RSP) ? line_mem[widx_q] : 32'h0;

    assign o_icb_cmd_valid = (state == S_FILL_CMD) | (state == S_PT_CMD);
    assign o_icb_cmd_read  = (state == S_FILL_CMD);
    assign o_icb_cmd_addr  = (state == S_FILL_CMD) ? {tag_q, cnt, 2'b00} :
                             (state == S_PT_CMD)   ? {addr_q, 2'b00} : '0;
    assign o_icb_cmd_wdata = (state == S_PT_CMD) ? wdata_q : 32'h0;
    assign o_icb_rsp_ready = (state == S_FILL_RSP) | ((state == S_PT_RSP) & ~pt_done);

endmodule
`default_nettype wire

// File: tb/tb_ux607_qspi_xip_linebuf.sv
`default_nettype none
// ============================================================================
// tb_ux607_qspi_xip_linebuf
//   Directed bench: vector table plus invalidate, stall and reset sequences.
//   Revision: 1.0
// ============================================================================
module tb_ux607_qspi_xip_linebuf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_icb_cmd_valid = 1'b0;
    logic        i_icb_cmd_ready;
    logic [31:0] i_icb_cmd_addr = '0;
    logic        i_icb_cmd_read = 1'b0;
    logic [31:0] i_icb_cmd_wdata = '0;
    logic        i_icb_rsp_valid;
    logic        i_icb_rsp_ready = 1'b0;
    logic [31:0] i_icb_rsp_rdata;
    logic        o_icb_cmd_valid;
    logic        o_icb_cmd_ready = 1'b1;
    logic [31:0] o_icb_cmd_addr;
    logic        o_icb_cmd_read;
    logic [31:0] o_icb_cmd_wdata;
    logic        o_icb_rsp_valid = 1'b0;
    logic        o_icb_rsp_ready;
    logic [31:0] o_icb_rsp_rdata = '0;
    logic        invalidate = 1'b0;

    ux607_qspi_xip_linebuf #(.PA_SIZE(32), .LINE_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_icb_cmd_valid(i_icb_cmd_valid), .i_icb_cmd_ready(i_icb_cmd_ready),
        .i_icb_cmd_addr(i_icb_cmd_addr), .i_icb_cmd_read(i_icb_cmd_read),
        .i_icb_cmd_wdata(i_icb_cmd_wdata), .i_icb_rsp_valid(i_icb_rsp_valid),
        .i_icb_rsp_ready(i_icb_rsp_ready), .i_icb_rsp_rdata(i_icb_rsp_rdata),
        .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
        .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_read(o_icb_cmd_read),
        .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_rsp_valid(o_icb_rsp_valid),
        .o_icb_rsp_ready(o_icb_rsp_ready), .o_icb_rsp_rdata(o_icb_rsp_rdata),
        .invalidate(invalidate)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Downstream QSPI model: one-cycle response, read data 0xA0 + addr[7:2].
    int          ds_reads = 0;
    int          ds_writes = 0;
    int          ds_stall = 0;
    int          stall_cycles = 0;
    int          stall_unstable = 0;
    logic        ds_busy = 1'b0;
    logic [31:0] ds_data = '0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic        last_wread = 1'b1;
    logic [31:0] rd_log [$];
    logic        prev_stalled = 1'b0;
    logic [31:0] prev_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ds_busy = 1'b0;
                o_icb_rsp_valid = 1'b0;
                o_icb_rsp_rdata = '0;
                o_icb_cmd_ready = 1'b1;
                prev_stalled = 1'b0;
            end else begin
                o_icb_cmd_ready = (ds_stall == 0);
                if (ds_stall > 0) ds_stall--;
                o_icb_rsp_valid = ds_busy;
                o_icb_rsp_rdata = ds_busy ? ds_data : 32'h0;
                #1;
                if (o_icb_cmd_valid && !o_icb_cmd_ready) begin
                    stall_cycles++;
                    if (prev_stalled && (o_icb_cmd_addr !== prev_addr)) stall_unstable++;
                    prev_stalled = 1'b1;
                    prev_addr = o_icb_cmd_addr;
                end else begin
                    prev_stalled = 1'b0;
                end
                if (o_icb_rsp_valid && o_icb_rsp_ready) ds_busy = 1'b0;
                if (o_icb_cmd_valid && o_icb_cmd_ready) begin
                    ds_busy = 1'b1;
                    if (o_icb_cmd_read) begin
                        ds_reads++;
                        rd_log.push_back(o_icb_cmd_addr);
                        ds_data = 32'hA0 + {26'd0, o_icb_cmd_addr[7:2]};
                    end else begin
                        ds_writes++;
                        last_waddr = o_icb_cmd_addr;
                        last_wdata = o_icb_cmd_wdata;
                        last_wread = o_icb_cmd_read;
                        ds_data = 32'hDEAD_BEEF;
                    end
                end
            end
        end
    end

    // One upstream transaction; reports data, latency, stability and busy-ready errors.
    task automatic up_txn(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                          input int hold, input logic inv, output logic [31:0] data,
                          output int lat, output int unstable, output int rdy_err);
        int n;
        unstable = 0;
        rdy_err = 0;
        data = '0;
        @(negedge clk);
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_addr  = a;
        i_icb_cmd_read  = rd;
        i_icb_cmd_wdata = wd;
        i_icb_rsp_ready = 1'b0;
        n = 0;
        while (!i_icb_cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        invalidate = inv;
        @(negedge clk);
        i_icb_cmd_valid = 1'b0;
        invalidate = 1'b0;
        lat = 1;
        n = 0;
        while (!i_icb_rsp_valid && n < 200) begin
            if (i_icb_cmd_ready) rdy_err++;
            @(negedge clk);
            lat++;
            n++;
        end
        if (!i_icb_rsp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: addr 0x%08h got no response, expected one", a);
        end else begin
            data = i_icb_rsp_rdata;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (!i_icb_rsp_valid || (i_icb_rsp_rdata !== data)) unstable++;
                if (i_icb_cmd_ready) rdy_err++;
            end
            i_icb_rsp_ready = 1'b1;
            @(negedge clk);
            i_icb_rsp_ready = 1'b0;
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wd;
        logic [31:0] exp_data;
        int          exp_reads;
        int          exp_writes;
        logic        exp_hit;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [31:0] data;
        int lat, unst, rerr, base_r, base_w, n;
        logic fill_ok;

        vecs[0] = '{32'h2000_0104, 1'b1, 32'h0,  32'hA1, 4, 0, 1'b0};
        vecs[1] = '{32'h2000_0108, 1'b1, 32'h0,  32'hA2, 0, 0, 1'b1};
        vecs[2] = '{32'h2000_010C, 1'b1, 32'h0,  32'hA3, 0, 0, 1'b1};
        vecs[3] = '{32'h2000_0100, 1'b1, 32'h0,  32'hA0, 0, 0, 1'b1};
        vecs[4] = '{32'h1000_0040, 1'b0, 32'h5A, 32'h0,  0, 1, 1'b0};
        vecs[5] = '{32'h2000_0100, 1'b1, 32'h0,  32'hA0, 4, 0, 1'b0};
        vecs[6] = '{32'h2000_012E, 1'b1, 32'h0,  32'hAB, 4, 0, 1'b0};
        vecs[7] = '{32'h2000_0124, 1'b1, 32'h0,  32'hA9, 0, 0, 1'b1};
        vecs[8] = '{32'h2000_0104, 1'b1, 32'h0,  32'hA1, 4, 0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_valids", {29'd0, i_icb_rsp_valid, o_icb_cmd_valid, o_icb_rsp_ready}, 32'h0);
        chk("reset_cmd_addr", o_icb_cmd_addr, 32'h0);
        chk("reset_rsp_rdata", i_icb_rsp_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", {31'd0, i_icb_cmd_ready}, 32'h1);

        for (int v = 0; v < 9; v++) begin
            base_r = ds_reads;
            base_w = ds_writes;
            rd_log.delete();
            up_txn(vecs[v].addr, vecs[v].rd, vecs[v].wd, 0, 1'b0, data, lat, unst, rerr);
            chk($sformatf("v%0d_rdata", v), data, vecs[v].exp_data);
            chk($sformatf("v%0d_ds_reads", v), ds_reads - base_r, vecs[v].exp_reads);
            chk($sformatf("v%0d_ds_writes", v), ds_writes - base_w, vecs[v].exp_writes);
            chk($sformatf("v%0d_hit_latency1", v), {31'd0, (lat == 1)}, {31'd0, vecs[v].exp_hit});
            if (vecs[v].exp_reads > 0) begin
                fill_ok = (rd_log.size() == vecs[v].exp_reads);
                for (int k = 0; k < rd_log.size(); k++)
                    if (rd_log[k] !== ({vecs[v].addr[31:4], 4'h0} + 32'(4 * k))) fill_ok = 1'b0;
                chk($sformatf("v%0d_fill_order", v), {31'd0, fill_ok}, 32'h1);
            end
            if (!vecs[v].rd) begin
                chk("pt_waddr", last_waddr, 32'h1000_0040);
                chk("pt_wdata", last_wdata, 32'h5A);
                chk("pt_wread", {31'd0, last_wread}, 32'h0);
            end
        end

        // Invalidate during the second fill word: data still returned, line not kept
        base_r = ds_reads;
        fork
            up_txn(32'h2000_0204, 1'b1, 32'h0, 0, 1'b0, data, lat, unst, rerr);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    #2;
                    n++;
                end while (ds_reads < base_r + 2 && n < 100);
                invalidate = 1'b1;
                @(negedge clk);
                #2;
                invalidate = 1'b0;
            end
        join
        chk("inval_fill_rdata", data, 32'hA1);
        base_r = ds_reads;
        up_txn(32'h2000_0208, 1'b1, 32'h0, 0, 1'b0, data, lat, unst, rerr);
        chk("inval_refill_reads", ds_reads - base_r, 32'd4);
        chk("inval_refill_rdata", data, 32'hA2);

        // Invalidate coincident with an accept that would otherwise hit
        up_txn(32'h2000_0300, 1'b1, 32'h0, 0, 1'b0, data, lat, unst, rerr);
        base_r = ds_reads;
        up_txn(32'h2000_0304, 1'b1, 32'h0, 0, 1'b1, data, lat, unst, rerr);
        chk("inval_accept_reads", ds_reads - base_r, 32'd4);
        chk("inval_accept_rdata", data, 32'hA1);
        base_r = ds_reads;
        up_txn(32'h2000_0308, 1'b1, 32'h0, 0, 1'b0, data, lat, unst, rerr);
        chk("after_inval_hit_reads", ds_reads - base_r, 32'd0);
        chk("after_inval_hit_rdata", data, 32'hA2);

        // Invalidate while idle drops the line
        @(negedge clk);
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        base_r = ds_reads;
        up_txn(32'h2000_030C, 1'b1, 32'h0, 0, 1'b0, data, lat, unst, rerr);
        chk("idle_inval_reads", ds_reads - base_r, 32'd4);
        chk("idle_inval_rdata", data, 32'hA3);

        // Downstream command stall and upstream response backpressure
        stall_cycles = 0;
        stall_unstable = 0;
        ds_stall = 8;
        up_txn(32'h2000_0404, 1'b1, 32'h0, 3, 1'b0, data, lat, unst, rerr);
        chk("stall_rdata", data, 32'hA1);
        chk("stall_seen_ge5", {31'd0, (stall_cycles >= 5)}, 32'h1);
        chk("stall_cmd_stable", stall_unstable, 32'd0);
        chk("hold_rsp_stable", unst, 32'd0);
        chk("busy_cmd_ready_low", rerr, 32'd0);

        // Reset asserted while a fill response is outstanding
        base_r = ds_reads;
        @(negedge clk);
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_addr  = 32'h2000_0504;
        i_icb_cmd_read  = 1'b1;
        @(negedge clk);
        i_icb_cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (ds_reads < base_r + 2 && n < 100);
        @(posedge clk);
        #1;
        chk("pre_reset_fill_rsp", {31'd0, o_icb_rsp_ready}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valids", {29'd0, i_icb_rsp_valid, o_icb_cmd_valid, o_icb_rsp_ready}, 32'h0);
        chk("mid_reset_cmd_addr", o_icb_cmd_addr, 32'h0);
        chk("mid_reset_cmd_read", {31'd0, o_icb_cmd_read}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base_r = ds_reads;
        up_txn(32'h2000_0504, 1'b1, 32'h0, 0, 1'b0, data, lat, unst, rerr);
        chk("post_reset_reads", ds_reads - base_r, 32'd4);
        chk("post_reset_rdata", data, 32'hA1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ux607_qspi_xip_linebuf.md
Name: ux607_qspi_xip_linebuf

Overview:
- Single-line XIP read buffer directly upstream of the QSPI 1-CS ICB top. Sits between the system ICB fabric and the QSPI ICB slave port.
- Serves repeated word reads from one cached flash line.
- On a read miss, fetches a whole line with back-to-back single-word downstream reads.
- Writes pass straight through and invalidate the line.

Parameters:
- PA_SIZE, 32, physical address width; matches `UX607_PA_SIZE.
- LINE_WORDS, 4, 32-bit words per line; power of two, 2..16.
- Derived: WIDX = log2(LINE_WORDS); tag = addr[PA_SIZE-1:WIDX+2]; word index = addr[WIDX+1:2].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_icb_cmd_valid  in  1  upstream command valid
- i_icb_cmd_ready  out  1  upstream command ready
- i_icb_cmd_addr  in  PA_SIZE  byte address; bits[1:0] ignored
- i_icb_cmd_read  in  1  1=read, 0=write
- i_icb_cmd_wdata  in  32  write data
- i_icb_rsp_valid  out  1  upstream response valid
- i_icb_rsp_ready  in  1  upstream response ready
- i_icb_rsp_rdata  out  32  read data; 0 for writes
- o_icb_cmd_valid  out  1  downstream command valid, to QSPI top
- o_icb_cmd_ready  in  1  downstream command ready
- o_icb_cmd_addr  out  PA_SIZE  downstream address, always word-aligned
- o_icb_cmd_read  out  1  downstream read/write
- o_icb_cmd_wdata  out  32  downstream write data
- o_icb_rsp_valid  in  1  downstream response valid
- o_icb_rsp_ready  out  1  downstream response ready
- o_icb_rsp_rdata  in  32  downstream read data
- invalidate  in  1  single-cycle pulse that drops the line (flash reprogrammed or mode change)

Behaviour:
- Reset: all outputs 0, state IDLE, line_valid=0, fill counter=0, pending_inval=0.
- Clock and reset: single clock domain; reset asynchronous assert, synchronous deassert handled externally.
- Outstanding transactions: one upstream and at most one downstream at any time.
- i_icb_cmd_ready = (state==IDLE), combinational from state only.
- States: IDLE, HIT_RSP, FILL_CMD, FILL_RSP, MISS_RSP, PT_CMD, PT_RSP.
- IDLE accepts a command on cmd_valid&cmd_ready, latching addr/read/wdata.
  - Hit is read & line_valid & tag match & !invalidate → HIT_RSP. rdata = line[widx], registered, so rsp_valid appears the cycle after accept (latency 1).
  - Read miss → FILL_CMD, counter=0, line_valid cleared.
  - Write → PT_CMD, line_valid cleared.
- FILL_CMD:
  - o_cmd_valid=1, read=1, addr={tag,counter,2'b00}.
  - On o_cmd_ready → FILL_RSP.
- FILL_RSP:
  - o_rsp_ready=1.
  - On o_rsp_valid, store rdata into line[counter].
  - If counter==LINE_WORDS-1 → MISS_RSP and set line_valid unless pending_inval. Otherwise counter+1 → FILL_CMD.
  - Fill order is always word 0 upward; no critical-word-first.
- MISS_RSP: i_rsp_valid=1, rdata=line[latched widx]. On i_rsp_ready → IDLE and clear pending_inval.
- PT_CMD: forward latched addr (word-aligned), read=0, wdata. On o_cmd_ready → PT_RSP.
- PT_RSP: o_rsp_ready=1. On o_rsp_valid, capture and return as i_rsp with rdata=0; on i_rsp_ready → IDLE.
- HIT_RSP: hold rsp_valid/rdata stable until i_rsp_ready, then → IDLE.
- Response stability: every i_rsp holds valid and data constant while ready is low; all o_cmd fields hold constant while o_cmd_ready is low.
- invalidate handling:
  - In IDLE or HIT_RSP: clears line_valid next edge; a HIT_RSP already entered still returns its data.
  - Coincident with an IDLE accept: the accept is treated as a miss.
  - During FILL_*: sets pending_inval; the fill completes and data is returned, but line_valid stays 0.
- Downstream error bits are not modelled; fabric errors are out of scope.
- Reset mid-fill: all state returns to reset values; the downstream response in flight is dropped (QSPI top is reset by the same rst_n).

Test Plan:
- Read 0x2000_0104 on empty line → 4 downstream reads to 0x2000_0100/104/108/10C returning 0xA0..0xA3 → upstream rdata 0xA1; line_valid=1.
- Then read 0x2000_0108 → no o_icb_cmd_valid; rsp_valid the cycle after accept, rdata 0xA2.
- Write 0x1000_0040 data 0x5A → one downstream write with read=0, wdata 0x5A; upstream rsp rdata 0. Then read 0x2000_0100 → refill of 4 words.
- Pulse invalidate during the 2nd fill word → response still correct; next read of the same line triggers a fresh 4-word fill.
- Stall o_icb_cmd_ready low for 5 cycles and i_icb_rsp_ready low for 3 cycles → o_cmd addr and i_rsp data remain stable; i_icb_cmd_ready stays 0 throughout.
- Assert rst_n=0 during FILL_RSP → all outputs 0 immediately; first read after release performs a full miss fill.
